// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: decodes IF/ID, reads the register file,
// detects load-use hazards and registers operands/control into ID/EX.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc4,
  input  logic        flush,
  output logic        id_stall,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dest,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_illegal
);

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR  = 3'd3, ALU_SLT = 3'd4, ALU_PASSB = 3'd5;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_zext, imm_lui;

  assign opcode   = if_instr[31:26];
  assign funct    = if_instr[5:0];
  assign rs       = if_instr[25:21];
  assign rt       = if_instr[20:16];
  assign rd       = if_instr[15:11];
  assign imm_sext = {{16{if_instr[15]}}, if_instr[15:0]};
  assign imm_zext = {16'h0000, if_instr[15:0]};
  assign imm_lui  = {if_instr[15:0], 16'h0000};

  assign rf_rs_addr = rs;
  assign rf_rt_addr = rt;

  logic        dec_illegal, dec_alu_src, dec_mem_read, dec_mem_write;
  logic        dec_wr_en, dec_branch, dec_rt_src;
  logic [2:0]  dec_alu_op;
  logic [4:0]  dec_dest;
  logic [31:0] dec_imm;

  always_comb begin
    dec_illegal   = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_alu_src   = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_wr_en     = 1'b0;
    dec_branch    = 1'b0;
    dec_rt_src    = 1'b0;
    dec_dest      = 5'd0;
    dec_imm       = 32'd0;
    unique case (opcode)
      6'h00: begin
        dec_rt_src = 1'b1;
        dec_dest   = rd;
        dec_wr_en  = 1'b1;
        case (funct)
          6'h20:   dec_alu_op = ALU_ADD;
          6'h22:   dec_alu_op = ALU_SUB;
          6'h24:   dec_alu_op = ALU_AND;
          6'h25:   dec_alu_op = ALU_OR;
          6'h2A:   dec_alu_op = ALU_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h23: begin
        dec_imm = imm_sext; dec_alu_src = 1'b1; dec_mem_read = 1'b1;
        dec_wr_en = 1'b1; dec_dest = rt;
      end
      6'h2B: begin
        dec_imm = imm_sext; dec_alu_src = 1'b1; dec_mem_write = 1'b1;
        dec_rt_src = 1'b1;
      end
      6'h04: begin
        dec_imm = imm_sext; dec_alu_op = ALU_SUB; dec_branch = 1'b1;
        dec_rt_src = 1'b1;
      end
      6'h08: begin
        dec_imm = imm_sext; dec_alu_src = 1'b1; dec_wr_en = 1'b1; dec_dest = rt;
      end
      6'h0C: begin
        dec_imm = imm_zext; dec_alu_op = ALU_AND; dec_alu_src = 1'b1;
        dec_wr_en = 1'b1; dec_dest = rt;
      end
      6'h0D: begin
        dec_imm = imm_zext; dec_alu_op = ALU_OR; dec_alu_src = 1'b1;
        dec_wr_en = 1'b1; dec_dest = rt;
      end
      6'h0F: begin
        dec_imm = imm_lui; dec_alu_op = ALU_PASSB; dec_alu_src = 1'b1;
        dec_wr_en = 1'b1; dec_dest = rt;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Only a load still sitting in ID/EX can create a hazard; rt counts only when read.
  logic hazard, bubble;
  assign hazard = ex_valid & ex_mem_read & (ex_dest != 5'd0) & if_valid &
                  ((ex_dest == rs) | (dec_rt_src & (ex_dest == rt)));
  assign id_stall = hazard & ~flush;
  assign bubble   = flush | hazard | ~if_valid;

  logic        valid_d, alu_src_d, mem_read_d, mem_write_d, reg_write_d, branch_d, illegal_d;
  logic [2:0]  alu_op_d;
  logic [4:0]  rs_d, rt_d, dest_d;
  logic [31:0] pc4_d, rs_val_d, rt_val_d, imm_d;

  always_comb begin
    valid_d     = 1'b0;
    pc4_d       = 32'd0;
    rs_val_d    = 32'd0;
    rt_val_d    = 32'd0;
    imm_d       = 32'd0;
    rs_d        = 5'd0;
    rt_d        = 5'd0;
    dest_d      = 5'd0;
    alu_op_d    = 3'd0;
    alu_src_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    branch_d    = 1'b0;
    illegal_d   = 1'b0;
    if (!bubble) begin
      valid_d     = 1'b1;
      pc4_d       = if_pc4;
      rs_val_d    = rf_rs_data;
      rt_val_d    = rf_rt_data;
      imm_d       = dec_imm;
      rs_d        = rs;
      rt_d        = rt;
      dest_d      = dec_dest;
      alu_op_d    = dec_alu_op;
      alu_src_d   = dec_alu_src;
      illegal_d   = dec_illegal;
      mem_read_d  = dec_mem_read & ~dec_illegal;
      mem_write_d = dec_mem_write & ~dec_illegal;
      branch_d    = dec_branch & ~dec_illegal;
      reg_write_d = dec_wr_en & ~dec_illegal & (dec_dest != 5'd0);
    end
  end

  logic        valid_q, alu_src_q, mem_read_q, mem_write_q, reg_write_q, branch_q, illegal_q;
  logic [2:0]  alu_op_q;
  logic [4:0]  rs_q, rt_q, dest_q;
  logic [31:0] pc4_q, rs_val_q, rt_val_q, imm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc4_q       <= 32'd0;
      rs_val_q    <= 32'd0;
      rt_val_q    <= 32'd0;
      imm_q       <= 32'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      dest_q      <= 5'd0;
      alu_op_q    <= 3'd0;
      alu_src_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc4_q       <= pc4_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc4       = pc4_q;
  assign ex_rs_val    = rs_val_q;
  assign ex_rt_val    = rt_val_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_dest      = dest_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_alu_src   = alu_src_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_reg_write = reg_write_q;
  assign ex_branch    = branch_q;
  assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded MIPS words with hand-computed
// decode results, load-use stalls, flush priority and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4;
  logic        flush;
  logic        id_stall;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic        ex_valid;
  logic [31:0] ex_pc4, ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc4(if_pc4), .flush(flush), .id_stall(id_stall),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_val(ex_rs_val),
    .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc4);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc4   = pc4;
    $display("step instr=%h pc4=%h flush=%0b", instr, pc4, flush);
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc4 = 32'd0;
    flush = 1'b0; rf_rs_data = 32'd0; rf_rt_data = 32'd0;
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall", {31'd0, id_stall}, 32'd0);
    chk("rst_imm", ex_imm, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // addi $8,$0,-1
    issue(32'h2008FFFF, 32'h4); rf_rs_data = 32'h0; rf_rt_data = 32'h11;
    chk("addi_rs_addr", {27'd0, rf_rs_addr}, 32'd0);
    chk("addi_rt_addr", {27'd0, rf_rt_addr}, 32'd8);
    tick();
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_dest", {27'd0, ex_dest}, 32'd8);
    chk("addi_alu_op", {29'd0, ex_alu_op}, 32'd0);
    chk("addi_alu_src", {31'd0, ex_alu_src}, 32'd1);
    chk("addi_reg_write", {31'd0, ex_reg_write}, 32'd1);
    chk("addi_pc4", ex_pc4, 32'h4);
    chk("addi_rt_val", ex_rt_val, 32'h11);

    // ori $9,$0,0x8001
    issue(32'h34098001, 32'h8); tick();
    chk("ori_imm", ex_imm, 32'h00008001);
    chk("ori_alu_op", {29'd0, ex_alu_op}, 32'd3);
    chk("ori_dest", {27'd0, ex_dest}, 32'd9);

    // lui $9,0x1234
    issue(32'h3C091234, 32'hC); tick();
    chk("lui_imm", ex_imm, 32'h12340000);
    chk("lui_alu_op", {29'd0, ex_alu_op}, 32'd5);

    // lw $5,4($1) then add $6,$5,$2 -> one stall cycle
    issue(32'h8C250004, 32'h10); rf_rs_data = 32'h100; tick();
    chk("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
    chk("lw_dest", {27'd0, ex_dest}, 32'd5);
    chk("lw_imm", ex_imm, 32'h4);
    chk("lw_rs_val", ex_rs_val, 32'h100);
    issue(32'h00A23020, 32'h14); #1;
    chk("hz_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("hz_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("hz_bubble_mem_read", {31'd0, ex_mem_read}, 32'd0);
    chk("hz_released", {31'd0, id_stall}, 32'd0);
    tick();
    chk("hz_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("hz_add_rs", {27'd0, ex_rs}, 32'd5);
    chk("hz_add_dest", {27'd0, ex_dest}, 32'd6);
    chk("hz_add_alu_src", {31'd0, ex_alu_src}, 32'd0);
    chk("hz_add_reg_write", {31'd0, ex_reg_write}, 32'd1);

    // lw $5 then add $6,$2,$3 -> no stall
    issue(32'h8C250004, 32'h18); tick();
    issue(32'h00433020, 32'h1C); #1;
    chk("nohz_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("nohz_valid", {31'd0, ex_valid}, 32'd1);
    chk("nohz_rs", {27'd0, ex_rs}, 32'd2);

    // lw $5 then lw $6,0($5) -> stall
    issue(32'h8C250004, 32'h20); tick();
    issue(32'h8CA60000, 32'h24); #1;
    chk("lwlw_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("lwlw_bubble", {31'd0, ex_valid}, 32'd0);
    tick();
    chk("lwlw_valid", {31'd0, ex_valid}, 32'd1);
    chk("lwlw_dest", {27'd0, ex_dest}, 32'd6);

    // lw $0 then add $6,$0,$0 -> no stall
    issue(32'h8C200000, 32'h28); tick();
    chk("lw0_reg_write", {31'd0, ex_reg_write}, 32'd0);
    issue(32'h00003020, 32'h2C); #1;
    chk("lw0_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("lw0_add_valid", {31'd0, ex_valid}, 32'd1);

    // add $0,$1,$2 -> no register write
    issue(32'h00220020, 32'h30); tick();
    chk("add0_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("add0_valid", {31'd0, ex_valid}, 32'd1);

    // slt $4,$1,$2
    issue(32'h0022202A, 32'h34); tick();
    chk("slt_alu_op", {29'd0, ex_alu_op}, 32'd4);
    chk("slt_dest", {27'd0, ex_dest}, 32'd4);

    // hazard plus flush: flush wins, no stall, bubble
    issue(32'h8C250004, 32'h38); tick();
    flush = 1'b1;
    issue(32'h00A23020, 32'h3C); #1;
    chk("flush_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("flush_bubble", {31'd0, ex_valid}, 32'd0);
    chk("flush_mem_read", {31'd0, ex_mem_read}, 32'd0);
    flush = 1'b0;

    // opcode 0x3F -> illegal, controls cleared
    issue(32'hFC221234, 32'h40); tick();
    chk("ill_valid", {31'd0, ex_valid}, 32'd1);
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch}, 32'd0);

    // unknown R-type funct
    issue(32'h00223027, 32'h44); tick();
    chk("illr_flag", {31'd0, ex_illegal}, 32'd1);
    chk("illr_reg_write", {31'd0, ex_reg_write}, 32'd0);

    // beq $1,$2,3
    issue(32'h10220003, 32'h48); tick();
    chk("beq_branch", {31'd0, ex_branch}, 32'd1);
    chk("beq_alu_op", {29'd0, ex_alu_op}, 32'd1);
    chk("beq_alu_src", {31'd0, ex_alu_src}, 32'd0);
    chk("beq_dest", {27'd0, ex_dest}, 32'd0);
    chk("beq_illegal", {31'd0, ex_illegal}, 32'd0);

    // sw $2,-8($1)
    issue(32'hAC22FFF8, 32'h4C); tick();
    chk("sw_imm", ex_imm, 32'hFFFFFFF8);
    chk("sw_mem_write", {31'd0, ex_mem_write}, 32'd1);
    chk("sw_reg_write", {31'd0, ex_reg_write}, 32'd0);

    // if_valid low -> bubble
    if_valid = 1'b0; tick();
    chk("inval_bubble", {31'd0, ex_valid}, 32'd0);

    // reset asserted during a stall
    issue(32'h8C250004, 32'h50); tick();
    issue(32'h00A23020, 32'h54); #1;
    chk("rstmid_pre_stall", {31'd0, id_stall}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rstmid_stall", {31'd0, id_stall}, 32'd0);
    chk("rstmid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rstmid_pc4", ex_pc4, 32'd0);
    chk("rstmid_mem_read", {31'd0, ex_mem_read}, 32'd0);
    #1 rst_n = 1'b1;
    issue(32'h2008FFFF, 32'h58); tick();
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    chk("post_rst_imm", ex_imm, 32'hFFFFFFFF);
    chk("post_rst_pc4", ex_pc4, 32'h58);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
